// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : program_sequencer
// Purpose : Loadable 16-word program memory that issues packed 21-bit words
//           to the CPU instruction port, one per clock, with optional looping.
// Rev     : 1.0
// ============================================================================
module program_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 21
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_z,
    input  logic [2:0]    wr_op,
    input  logic [7:0]    wr_im,
    input  logic [2:0]    wr_src1,
    input  logic [2:0]    wr_src2,
    input  logic [2:0]    wr_dst,
    input  logic          start,
    input  logic [AW-1:0] last_addr,
    input  logic          loop,
    input  logic          stall,
    input  logic          halt,
    output logic [IW-1:0] instruction,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_last;
    logic          r_loop;

    logic [IW-1:0] w_word;
    logic          w_wr_ok;

    assign w_word  = {wr_z, wr_op, wr_im, wr_src1, wr_src2, wr_dst};
    assign w_wr_ok = wr_en && (r_state != S_RUN);

    // Program memory is deliberately outside the reset domain so it survives rst.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            pc          <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            err         <= 1'b0;
            r_last      <= '0;
            r_loop      <= 1'b0;
        end else begin
            err <= wr_en && (r_state == S_RUN);
            case (r_state)
                S_IDLE, S_DONE: begin
                    // DONE retires the final word after its single valid cycle.
                    if (r_state == S_DONE) begin
                        instruction <= '0;
                        instr_valid <= 1'b0;
                    end
                    if (start) begin
                        r_last  <= last_addr;
                        r_loop  <= loop;
                        pc      <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (halt) begin
                        r_state     <= S_IDLE;
                        instruction <= '0;
                        instr_valid <= 1'b0;
                    end else if (!stall) begin
                        instruction <= r_mem[pc];
                        instr_valid <= 1'b1;
                        if (pc != r_last) begin
                            pc <= pc + 1'b1;
                        end else if (r_loop) begin
                            pc <= '0;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_program_sequencer
// Purpose : Self-checking bench: write-vector table plus scoreboarded runs.
// Rev     : 1.0
// ============================================================================
module tb_program_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int IW    = 21;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic          wr_z = 1'b0;
    logic [2:0]    wr_op = '0;
    logic [7:0]    wr_im = '0;
    logic [2:0]    wr_src1 = '0;
    logic [2:0]    wr_src2 = '0;
    logic [2:0]    wr_dst = '0;
    logic          start = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic          loop = 1'b0;
    logic          stall = 1'b0;
    logic          halt = 1'b0;
    logic [IW-1:0] instruction;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          err;

    program_sequencer #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_z(wr_z), .wr_op(wr_op),
        .wr_im(wr_im), .wr_src1(wr_src1), .wr_src2(wr_src2), .wr_dst(wr_dst),
        .start(start), .last_addr(last_addr), .loop(loop),
        .stall(stall), .halt(halt),
        .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          z;
        logic [2:0]    op;
        logic [7:0]    im;
        logic [2:0]    s1;
        logic [2:0]    s2;
        logic [2:0]    d;
        logic [IW-1:0] exp;
    } vec_t;

    vec_t          vecs [6];
    logic [IW-1:0] exp_mem [DEPTH];
    logic [IW-1:0] sb [$];
    int            checks = 0;
    int            errors = 0;
    int            epc;
    int            elast;
    bit            eloop;
    bit            edone;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Each new word seen while expectations are pending is matched in order.
    task automatic tick();
        @(posedge clk);
        #1;
        if (instr_valid && sb.size() > 0) chk("sb_word", instruction, sb.pop_front());
    endtask

    function automatic logic [IW-1:0] pack(logic z, logic [2:0] op, logic [7:0] im,
                                           logic [2:0] s1, logic [2:0] s2, logic [2:0] d);
        return {z, op, im, s1, s2, d};
    endfunction

    task automatic set_fields(input logic [AW-1:0] a, input logic z, input logic [2:0] op,
                              input logic [7:0] im, input logic [2:0] s1,
                              input logic [2:0] s2, input logic [2:0] d);
        wr_addr = a; wr_z = z; wr_op = op; wr_im = im;
        wr_src1 = s1; wr_src2 = s2; wr_dst = d;
    endtask

    task automatic start_prog(input int l, input bit lp);
        start = 1'b1; last_addr = AW'(l); loop = lp;
        tick();
        start = 1'b0;
        epc = 0; elast = l; eloop = lp; edone = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_pc", pc, 0);
    endtask

    task automatic issue(input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back(exp_mem[epc]);
            tick();
            chk("issue_valid", instr_valid, 1);
            if (epc == elast) begin
                if (eloop) epc = 0;
                else edone = 1'b1;
            end else begin
                epc = epc + 1;
            end
            chk("issue_pc", pc, epc);
            chk("issue_done", done, edone);
            chk("issue_busy", busy, !edone);
        end
    endtask

    task automatic finish_check();
        tick();
        chk("fin_valid", instr_valid, 0);
        chk("fin_instr", instruction, 0);
        chk("fin_done", done, 1);
        chk("fin_sb_drained", sb.size(), 0);
    endtask

    task automatic do_halt();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_busy", busy, 0);
        chk("halt_valid", instr_valid, 0);
        chk("halt_instr", instruction, 0);
        chk("halt_sb_drained", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'd0,  1'b0, 3'd3, 8'd45,  3'd7, 3'd0, 3'd0, 21'h065BC0};
        vecs[1] = '{4'd1,  1'b0, 3'd3, 8'd12,  3'd7, 3'd0, 3'd1, 21'h0619C1};
        vecs[2] = '{4'd2,  1'b1, 3'd7, 8'd255, 3'd7, 3'd7, 3'd7, 21'h1FFFFF};
        vecs[3] = '{4'd3,  1'b1, 3'd0, 8'd0,   3'd0, 3'd0, 3'd0, 21'h100000};
        vecs[4] = '{4'd15, 1'b0, 3'd5, 8'hA5,  3'd2, 3'd4, 3'd6, 21'h0B4AA6};
        vecs[5] = '{4'd4,  1'b0, 3'd1, 8'h01,  3'd0, 3'd1, 3'd0, 21'h020208};

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_instr", instruction, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        // Load: random fields everywhere, then the fixed vectors on top
        for (int a = 0; a < DEPTH; a++) begin
            set_fields(AW'(a), 1'($urandom), 3'($urandom), 8'($urandom),
                       3'($urandom), 3'($urandom), 3'($urandom));
            exp_mem[a] = pack(wr_z, wr_op, wr_im, wr_src1, wr_src2, wr_dst);
            wr_en = 1'b1; tick(); wr_en = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            set_fields(vecs[i].addr, vecs[i].z, vecs[i].op, vecs[i].im,
                       vecs[i].s1, vecs[i].s2, vecs[i].d);
            exp_mem[vecs[i].addr] = vecs[i].exp;
            wr_en = 1'b1; tick(); wr_en = 1'b0;
            chk("wr_err_idle", err, 0);
        end

        // Two-word program, no loop
        start_prog(1, 1'b0);
        chk("first_not_valid_yet", instr_valid, 0);
        issue(2);
        finish_check();
        tick();
        chk("done_sticky", done, 1);

        // Loop over 3 words, start while running is ignored
        start_prog(2, 1'b1);
        issue(7);
        start = 1'b1; last_addr = 4'd0;
        issue(1);
        start = 1'b0;
        issue(2);
        do_halt();

        // Stall 3 cycles at pc=1
        start_prog(3, 1'b0);
        issue(1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc, 1);
            chk("stall_instr", instruction, exp_mem[0]);
            chk("stall_valid", instr_valid, 1);
        end
        stall = 1'b0;
        issue(3);
        finish_check();

        // Write during RUN is dropped and flagged
        start_prog(2, 1'b1);
        issue(1);
        set_fields(4'd0, 1'b1, 3'd6, 8'h5A, 3'd1, 3'd2, 3'd3);
        wr_en = 1'b1;
        issue(1);
        wr_en = 1'b0;
        chk("err_pulse", err, 1);
        issue(1);
        chk("err_clear", err, 0);
        do_halt();
        start_prog(1, 1'b0);
        issue(2);
        finish_check();

        // Same-cycle write with start, then halt at pc=2
        set_fields(4'd0, 1'b0, 3'd2, 8'h3C, 3'd5, 3'd6, 3'd7);
        exp_mem[0] = 21'h047977;
        wr_en = 1'b1;
        start_prog(5, 1'b0);
        wr_en = 1'b0;
        issue(2);
        do_halt();
        chk("halt_pc", pc, 2);
        start_prog(1, 1'b0);
        issue(2);
        finish_check();

        // Single-word loop, then reset mid-run
        start_prog(0, 1'b1);
        issue(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("mid_rst_instr", instruction, 0);
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);

        // Full-depth run with no wrap
        start_prog(DEPTH - 1, 1'b0);
        issue(DEPTH);
        finish_check();
        chk("full_pc_hold", pc, DEPTH - 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
